apb_multi_slave_master: RTL and testbench

- Single-master APB requester that converts a simple valid/ready command port into APB SETUP/ACCESS transfers.
- Drives a shared address/control/write-data bus and one-hot PSELx across NO_OF_SLAVES completers.
- Multiplexes the selected completer's PRDATA/PREADY/PSLVERR back into a one-cycle response.
- Sits between a bus/register-access front end and the peripheral APB fabric.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_resp_mux.sv | 41 ++++
 rtl/apb_multi_slave_master.sv | 160 ++++++++++++++++
 tb/tb_apb_multi_slave_master.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared defaults, FSM state type and response type for the APB requester
// Purpose: common declarations imported by apb_resp_mux and apb_multi_slave_master.
// Contents: default bus widths/completer count, apb_state_t, apb_rsp_t.
package apb_pkg;

  localparam int APB_DATA_WIDTH    = 32;
  localparam int APB_ADDRESS_WIDTH = 32;
  localparam int APB_NO_OF_SLAVES  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_resp_mux.sv
// rtl/apb_resp_mux.sv - completer index decode and response selection
// Purpose: turns a completer index into a one-hot select, and picks the
//          addressed completer's PRDATA/PREADY/PSLVERR.
// Ports:
//   dec_idx    in  index to decode (taken from the incoming command address)
//   dec_onehot out one-hot form of dec_idx
//   sel_idx    in  index of the completer owning the current transfer
//   prdata     in  per-completer read data (unpacked)
//   pready     in  per-completer ready
//   pslverr    in  per-completer error
//   sel_rdata  out read data of completer sel_idx
//   sel_ready  out ready of completer sel_idx
//   sel_err    out error of completer sel_idx
module apb_resp_mux
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH   = APB_DATA_WIDTH,
  parameter int NO_OF_SLAVES = APB_NO_OF_SLAVES,
  parameter int IDX_WIDTH    = $clog2(NO_OF_SLAVES)
) (
  input  logic [IDX_WIDTH-1:0]    dec_idx,
  output logic [NO_OF_SLAVES-1:0] dec_onehot,
  input  logic [IDX_WIDTH-1:0]    sel_idx,
  input  logic [DATA_WIDTH-1:0]   prdata [NO_OF_SLAVES],
  input  logic [NO_OF_SLAVES-1:0] pready,
  input  logic [NO_OF_SLAVES-1:0] pslverr,
  output logic [DATA_WIDTH-1:0]   sel_rdata,
  output logic                    sel_ready,
  output logic                    sel_err
);

  // NO_OF_SLAVES is a power of two, so every index value names a real completer.
  always_comb begin
    dec_onehot          = '0;
    dec_onehot[dec_idx] = 1'b1;
    sel_rdata           = prdata[sel_idx];
    sel_ready           = pready[sel_idx];
    sel_err             = pslverr[sel_idx];
  end

endmodule

// File: rtl/apb_multi_slave_master.sv
// rtl/apb_multi_slave_master.sv - APB requester driving NO_OF_SLAVES completers from a valid/ready command port
// Purpose: accepts one command at a time, runs an APB SETUP/ACCESS transfer to the
//          completer chosen by the top address bits, returns a one-cycle response.
// Ports:
//   clock, reset                 rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready          command handshake (ready only while idle)
//   req_write/req_addr/req_wdata command direction, address, write data
//   rsp_valid/rsp_rdata/rsp_err  one-cycle response pulse, read data, error
//   PADDR/PWRITE/PWDATA          shared APB address/control/write data
//   PSELx/PENABLE                one-hot completer select, access phase
//   PRDATA/PREADY/PSLVERR        per-completer response inputs
module apb_multi_slave_master
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int ADDRESS_WIDTH  = APB_ADDRESS_WIDTH,
  parameter int NO_OF_SLAVES   = APB_NO_OF_SLAVES,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err,
  output logic [ADDRESS_WIDTH-1:0] PADDR,
  output logic                     PWRITE,
  output logic [DATA_WIDTH-1:0]    PWDATA,
  output logic [NO_OF_SLAVES-1:0]  PSELx,
  output logic                     PENABLE,
  input  logic [DATA_WIDTH-1:0]    PRDATA [NO_OF_SLAVES],
  input  logic [NO_OF_SLAVES-1:0]  PREADY,
  input  logic [NO_OF_SLAVES-1:0]  PSLVERR
);

  localparam int IW = $clog2(NO_OF_SLAVES);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Last ACCESS cycle count value before the timeout fires.
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  apb_state_t state, state_n;
  logic [IW-1:0]            idx_q, idx_n;
  logic [TW-1:0]            cnt_q, cnt_n;
  logic [ADDRESS_WIDTH-1:0] paddr_n;
  logic                     pwrite_n;
  logic [DATA_WIDTH-1:0]    pwdata_n;
  logic [NO_OF_SLAVES-1:0]  psel_n;
  logic                     penable_n;
  logic                     rsp_valid_n;
  logic [DATA_WIDTH-1:0]    rsp_rdata_n;
  logic                     rsp_err_n;

  logic [NO_OF_SLAVES-1:0]  dec_onehot;
  logic [DATA_WIDTH-1:0]    sel_rdata;
  logic                     sel_ready;
  logic                     sel_err;

  apb_resp_mux #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NO_OF_SLAVES(NO_OF_SLAVES),
    .IDX_WIDTH   (IW)
  ) u_resp_mux (
    .dec_idx   (req_addr[ADDRESS_WIDTH-1 -: IW]),
    .dec_onehot(dec_onehot),
    .sel_idx   (idx_q),
    .prdata    (PRDATA),
    .pready    (PREADY),
    .pslverr   (PSLVERR),
    .sel_rdata (sel_rdata),
    .sel_ready (sel_ready),
    .sel_err   (sel_err)
  );

  assign req_ready = (state == IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSELx     <= '0;
      PENABLE   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_n;
      idx_q     <= idx_n;
      cnt_q     <= cnt_n;
      PADDR     <= paddr_n;
      PWRITE    <= pwrite_n;
      PWDATA    <= pwdata_n;
      PSELx     <= psel_n;
      PENABLE   <= penable_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err   <= rsp_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx_q;
    cnt_n       = cnt_q;
    paddr_n     = PADDR;
    pwrite_n    = PWRITE;
    pwdata_n    = PWDATA;
    psel_n      = PSELx;
    penable_n   = PENABLE;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = rsp_rdata;
    rsp_err_n   = rsp_err;
    case (state)
      IDLE: begin
        if (req_valid) begin
          paddr_n  = req_addr;
          pwrite_n = req_write;
          pwdata_n = req_wdata;
          psel_n   = dec_onehot;
          idx_n    = req_addr[ADDRESS_WIDTH-1 -: IW];
          state_n  = SETUP;
        end
      end
      SETUP: begin
        penable_n = 1'b1;
        cnt_n     = '0;
        state_n   = ACCESS;
      end
      ACCESS: begin
        // A ready completer wins over a timeout landing on the same edge.
        if (sel_ready) begin
          psel_n      = '0;
          penable_n   = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = sel_err;
          rsp_rdata_n = PWRITE ? '0 : sel_rdata;
          state_n     = IDLE;
        end else if (TIMEOUT_CYCLES > 0 && cnt_q == TO_LAST) begin
          psel_n      = '0;
          penable_n   = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
          rsp_rdata_n = '0;
          state_n     = IDLE;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_multi_slave_master.sv
// tb/tb_apb_multi_slave_master.sv - randomized self-checking bench with a cycle-table reference model
module tb_apb_multi_slave_master;
  import apb_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int NS    = 4;
  localparam int TO    = 8;
  localparam int DEPTH = 4096;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid, req_ready, req_write;
  logic [AW-1:0]     req_addr;
  logic [DW-1:0]     req_wdata;
  logic              rsp_valid, rsp_err;
  logic [DW-1:0]     rsp_rdata;
  logic [AW-1:0]     paddr;
  logic              pwrite, penable;
  logic [DW-1:0]     pwdata;
  logic [NS-1:0]     psel;
  logic [DW-1:0]     prdata [NS];
  logic [NS-1:0]     pready, pslverr;

  apb_multi_slave_master #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NO_OF_SLAVES(NS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PSELx(psel), .PENABLE(penable),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_fail = 0;
  int free   = 0;
  bit noise_ones = 1'b0;

  // Expected outputs per cycle, and selected-completer input overrides per cycle.
  logic [NS-1:0] e_psel   [DEPTH];
  logic          e_pen    [DEPTH];
  logic          e_ready  [DEPTH];
  logic          e_rv     [DEPTH];
  apb_rsp_t      e_rsp    [DEPTH];
  logic [AW-1:0] e_paddr  [DEPTH];
  logic          e_pwrite [DEPTH];
  logic [DW-1:0] e_pwdata [DEPTH];
  logic          ov_on    [DEPTH];
  logic [1:0]    ov_idx   [DEPTH];
  logic          ov_rdy   [DEPTH];
  logic          ov_err   [DEPTH];
  logic [DW-1:0] ov_rdata [DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic idle_from(input int c);
    for (int n = c; n < DEPTH; n++) begin
      e_psel[n] = '0; e_pen[n] = 1'b0; e_ready[n] = 1'b1; e_rv[n] = 1'b0;
      e_rsp[n] = '0; e_paddr[n] = '0; e_pwrite[n] = 1'b0; e_pwdata[n] = '0;
      ov_on[n] = 1'b0; ov_idx[n] = '0; ov_rdy[n] = 1'b0; ov_err[n] = 1'b0; ov_rdata[n] = '0;
    end
  endtask

  // Transaction-level model: a command presented now is taken at the first idle
  // cycle, followed by one SETUP cycle and w+1 ACCESS cycles (capped at TO).
  task automatic schedule(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int w, input bit err, input logic [DW-1:0] rdata,
                          output int s, output int rspc);
    int acc, nacc;
    logic [1:0] idx;
    acc  = (cyc > free) ? cyc : free;
    s    = acc + 1;
    idx  = addr[AW-1 -: 2];
    nacc = (w < TO) ? w + 1 : TO;
    rspc = s + 1 + nacc;
    for (int n = s; n < DEPTH; n++) begin
      e_paddr[n] = addr; e_pwrite[n] = wr; e_pwdata[n] = wdata;
    end
    for (int n = s; n < rspc && n < DEPTH; n++) begin
      e_psel[n]  = 4'b0001 << idx;
      e_pen[n]   = (n != s);
      e_ready[n] = 1'b0;
    end
    for (int k = 0; k < nacc; k++) begin
      if (s + 1 + k < DEPTH) begin
        ov_on[s+1+k]    = 1'b1;
        ov_idx[s+1+k]   = idx;
        ov_rdy[s+1+k]   = (w < TO) && (k == w);
        ov_err[s+1+k]   = (k == w) ? err : 1'($urandom);
        ov_rdata[s+1+k] = (k == w) ? rdata : $urandom;
      end
    end
    if (rspc < DEPTH) begin
      e_rv[rspc]        = 1'b1;
      e_rsp[rspc].err   = (w < TO) ? err : 1'b1;
      e_rsp[rspc].rdata = ((w < TO) && !wr) ? rdata : '0;
    end
    free = rspc;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input int w, input bit err, input logic [DW-1:0] rdata,
                      output int s, output int rspc);
    schedule(wr, addr, wdata, w, err, rdata, s, rspc);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    while (cyc < s) step(1);
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
  endtask

  // Completer models: random noise on every lane, selected lane overridden from the table.
  always @(posedge clock) begin
    #1;
    for (int i = 0; i < NS; i++) prdata[i] = $urandom;
    pready  = noise_ones ? '1 : NS'($urandom);
    pslverr = noise_ones ? '1 : NS'($urandom);
    if (cyc < DEPTH && ov_on[cyc]) begin
      pready[ov_idx[cyc]]  = ov_rdy[cyc];
      pslverr[ov_idx[cyc]] = ov_err[cyc];
      prdata[ov_idx[cyc]]  = ov_rdata[cyc];
    end
  end

  always @(negedge clock) begin
    if (cyc < DEPTH) begin
      check("req_ready", req_ready, e_ready[cyc]);
      check("PSELx",     psel,      e_psel[cyc]);
      check("PENABLE",   penable,   e_pen[cyc]);
      check("PADDR",     paddr,     e_paddr[cyc]);
      check("PWRITE",    pwrite,    e_pwrite[cyc]);
      check("PWDATA",    pwdata,    e_pwdata[cyc]);
      check("rsp_valid", rsp_valid, e_rv[cyc]);
      if (e_rv[cyc]) begin
        check("rsp_err",   rsp_err,   e_rsp[cyc].err);
        check("rsp_rdata", rsp_rdata, e_rsp[cyc].rdata);
      end
    end
  end

  initial begin
    int s, r;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < NS; i++) prdata[i] = '0;
    pready = '0; pslverr = '0;
    idle_from(0);
    #1 reset = 1'b1;
    step(1);
    check("rst_psel", psel, 4'b0000);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    step(1);
    reset = 1'b0;
    free = cyc;

    // zero-wait write to completer 1
    xfer(1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'h5A5A_5A5A, s, r);
    check("zw_psel_setup", psel, 4'b0010);
    check("zw_pen_setup", penable, 1'b0);
    check("zw_latency", r - s, 2);
    step(1);
    check("zw_pen_access", penable, 1'b1);
    step(1);
    check("zw_rsp_valid", rsp_valid, 1'b1);
    check("zw_rsp_err", rsp_err, 1'b0);
    check("zw_rsp_rdata", rsp_rdata, 32'h0);

    // read with two wait states from completer 3
    xfer(1'b0, 32'hC000_0004, 32'h0, 2, 1'b0, 32'h1234_5678, s, r);
    check("ws_len", r - s, 4);
    while (cyc < r) step(1);
    check("ws_rdata", rsp_rdata, 32'h1234_5678);

    // error response with error/ready noise on other completers
    noise_ones = 1'b1;
    xfer(1'b0, 32'h0000_0000, 32'h0, 0, 1'b1, 32'h7777_0000, s, r);
    while (cyc < r) step(1);
    check("err_slv0", rsp_err, 1'b1);
    xfer(1'b1, 32'h8000_0020, 32'hCAFE_0002, 1, 1'b0, 32'h0, s, r);
    while (cyc < r) step(1);
    check("err_slv2_clear", rsp_err, 1'b0);
    xfer(1'b0, 32'h4000_0000, 32'h0, 3, 1'b0, 32'h0BAD_F00D, s, r);
    step(2);
    check("noise_hold_pen", penable, 1'b1);
    check("noise_no_rsp", rsp_valid, 1'b0);
    while (cyc < r) step(1);
    check("noise_rdata", rsp_rdata, 32'h0BAD_F00D);
    noise_ones = 1'b0;

    // ready on the last allowed ACCESS cycle, then a full timeout
    xfer(1'b0, 32'h8000_0040, 32'h0, TO - 1, 1'b0, 32'h3C3C_3C3C, s, r);
    while (cyc < r) step(1);
    check("edge_err", rsp_err, 1'b0);
    check("edge_rdata", rsp_rdata, 32'h3C3C_3C3C);
    xfer(1'b0, 32'h4000_0100, 32'h0, 1000, 1'b0, 32'h0, s, r);
    check("to_len", r - s, 9);
    while (cyc < r) step(1);
    check("to_rsp_valid", rsp_valid, 1'b1);
    check("to_rsp_err", rsp_err, 1'b1);
    check("to_rsp_rdata", rsp_rdata, 32'h0);
    check("to_psel_idle", psel, 4'b0000);

    // reset while in ACCESS
    xfer(1'b0, 32'hC000_0008, 32'h0, 5, 1'b0, 32'hAAAA_5555, s, r);
    step(2);
    check("abort_pen_before", penable, 1'b1);
    idle_from(cyc);
    #2 reset = 1'b1;
    #1;
    check("abort_psel_async", psel, 4'b0000);
    check("abort_pen_async", penable, 1'b0);
    step(2);
    reset = 1'b0;
    free = cyc;
    check("abort_req_ready", req_ready, 1'b1);

    // randomized traffic, commands sometimes presented while busy
    for (int t = 0; t < 150; t++) begin
      int target;
      target = free + int'($urandom_range(0, 4)) - 2;
      while (cyc < target) step(1);
      xfer(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 9)), 1'($urandom), $urandom, s, r);
    end
    while (cyc < free + 3) step(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
